collision_matrix_controller: RTL and testbench

//  Generalised N-object collision detector for the VGA game path. Takes one drawing

---
 rtl/collision_matrix_controller.sv | 107 ++++++++++
 tb/tb_collision_matrix_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_matrix_controller.sv
// N-object pairwise overlap detector: per-pair once-per-frame hit pulses with frame cooldown,
// plus per-frame hit summaries for the game FSM.
module collision_matrix_controller #(
    parameter int                         N_OBJ           = 6,
    parameter logic [N_OBJ*N_OBJ-1:0]     PAIR_EN         = {N_OBJ*N_OBJ{1'b1}},
    parameter int                         COOLDOWN_FRAMES = 0,
    parameter int                         CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [N_OBJ-1:0]       drawing_request,
    input  logic [N_OBJ*N_OBJ-1:0] pair_mask,
    output logic                   collision,
    output logic [N_OBJ*N_OBJ-1:0] pair_hit_pulse,
    output logic                   SingleHitPulse,
    output logic [N_OBJ*N_OBJ-1:0] pair_frame_flag,
    output logic [CNT_W-1:0]       hits_last_frame
);

    localparam int         NP      = N_OBJ * N_OBJ;
    localparam int         SUM_W   = CNT_W + 8;
    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);
    localparam logic [SUM_W-1:0] CNT_MAX = {{8{1'b0}}, {CNT_W{1'b1}}};

    logic [NP-1:0]    r_seen;
    logic             r_frame_hit;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_cd [NP];

    logic [NP-1:0]    w_raw;
    logic [NP-1:0]    w_pulse;
    logic [SUM_W-1:0] w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_unused_mask;

    // Only the upper triangle (i<j) of the matrix carries a pair.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            for (int j = i + 1; j < N_OBJ; j++) begin
                w_raw[i*N_OBJ+j] = drawing_request[i] & drawing_request[j]
                                 & PAIR_EN[i*N_OBJ+j] & pair_mask[i*N_OBJ+j];
            end
        end
    end

    always_comb begin
        w_pulse = '0;
        w_pop   = '0;
        for (int p = 0; p < NP; p++) begin
            w_pulse[p] = w_raw[p] & ~r_seen[p] & (r_cd[p] == 8'd0);
            w_pop      = w_pop + SUM_W'(w_pulse[p]);
        end
    end

    assign w_sum      = SUM_W'(r_cnt) + w_pop;
    assign w_cnt_next = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    // Lower-triangle mask bits have no pair behind them.
    assign w_unused_mask = ^pair_mask;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision       <= 1'b0;
            pair_hit_pulse  <= '0;
            SingleHitPulse  <= 1'b0;
            pair_frame_flag <= '0;
            hits_last_frame <= '0;
            r_seen          <= '0;
            r_frame_hit     <= 1'b0;
            r_cnt           <= '0;
            // NOTE: the cooldown array is reset explicitly; a stale count after
            // reset would silently swallow the first hit.
            for (int p = 0; p < NP; p++) r_cd[p] <= 8'd0;
        end else begin
            collision      <= |w_raw;
            pair_hit_pulse <= w_pulse;
            SingleHitPulse <= (|w_pulse) & ~r_frame_hit;

            // A fresh pulse reloads the cooldown even on the frame-start cycle.
            for (int p = 0; p < NP; p++) begin
                if (w_pulse[p])
                    r_cd[p] <= CD_LOAD;
                else if (startOfFrame && r_cd[p] != 8'd0)
                    r_cd[p] <= r_cd[p] - 8'd1;
            end

            if (startOfFrame) begin
                pair_frame_flag <= r_seen | w_raw;
                hits_last_frame <= w_cnt_next;
                r_seen          <= '0;
                r_frame_hit     <= 1'b0;
                r_cnt           <= '0;
            end else begin
                r_seen <= r_seen | w_raw;
                r_cnt  <= w_cnt_next;
                if (|w_pulse) r_frame_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_collision_matrix_controller.sv
// Directed bench for collision_matrix_controller: three instances cover cooldown-free,
// two-frame cooldown and a 4-object / 2-bit-counter / disabled-pair configuration.
module tb_collision_matrix_controller;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic [2:0]  req_a = '0, req_b = '0;
    logic [3:0]  req_c = '0;
    logic [8:0]  mask_a = '1, mask_b = '1;
    logic [15:0] mask_c = '1;

    logic        col_a, shp_a, col_b, shp_b, col_c, shp_c;
    logic [8:0]  php_a, flag_a, php_b, flag_b;
    logic [15:0] php_c, flag_c;
    logic [7:0]  hits_a, hits_b;
    logic [1:0]  hits_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    collision_matrix_controller #(.N_OBJ(3), .COOLDOWN_FRAMES(0), .CNT_W(8)) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .drawing_request(req_a),
        .pair_mask(mask_a), .collision(col_a), .pair_hit_pulse(php_a),
        .SingleHitPulse(shp_a), .pair_frame_flag(flag_a), .hits_last_frame(hits_a));

    collision_matrix_controller #(.N_OBJ(3), .COOLDOWN_FRAMES(2), .CNT_W(8)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .drawing_request(req_b),
        .pair_mask(mask_b), .collision(col_b), .pair_hit_pulse(php_b),
        .SingleHitPulse(shp_b), .pair_frame_flag(flag_b), .hits_last_frame(hits_b));

    collision_matrix_controller #(.N_OBJ(4), .PAIR_EN(16'hFFFD), .COOLDOWN_FRAMES(0), .CNT_W(2)) dut_c (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .drawing_request(req_c),
        .pair_mask(mask_c), .collision(col_c), .pair_hit_pulse(php_c),
        .SingleHitPulse(shp_c), .pair_frame_flag(flag_c), .hits_last_frame(hits_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #3;
        vectors++;
        if ({col_a, php_a, shp_a, flag_a, hits_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got %h expected 0", {col_a, php_a, shp_a, flag_a, hits_a});
        end
        vectors++;
        if ({col_c, php_c, shp_c, flag_c, hits_c} !== '0) begin
            miscompares++;
            $display("FAIL reset_c: got %h expected 0", {col_c, php_c, shp_c, flag_c, hits_c});
        end
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic test_single_pair();
        int n_col = 0, n_pulse = 0, n_shp = 0;
        req_a = 3'b011;
        for (int k = 0; k < 5; k++) begin
            step();
            if (col_a === 1'b1) n_col++;
            if (php_a[1] === 1'b1) n_pulse++;
            if (shp_a === 1'b1) n_shp++;
            if (k == 0) begin
                vectors++;
                if (php_a !== 9'h002 || shp_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_first: pulse=%h shp=%b expected 002/1", php_a, shp_a);
                end
            end
        end
        req_a = 3'b000;
        step();
        vectors++;
        if (col_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_col_drop: got %b expected 0", col_a);
        end
        vectors++;
        if (n_col != 5 || n_pulse != 1 || n_shp != 1) begin
            miscompares++;
            $display("FAIL single_counts: col=%0d pulse=%0d shp=%0d expected 5/1/1", n_col, n_pulse, n_shp);
        end
        frame_start();
        vectors++;
        if (hits_a !== 8'd1 || flag_a !== 9'h002) begin
            miscompares++;
            $display("FAIL single_frame: hits=%0d flag=%h expected 1/002", hits_a, flag_a);
        end
    endtask

    task automatic test_all_pairs();
        req_a = 3'b111;
        step();
        vectors++;
        if (php_a !== 9'h026 || shp_a !== 1'b1) begin
            miscompares++;
            $display("FAIL all_pulse: pulse=%h shp=%b expected 026/1", php_a, shp_a);
        end
        req_a = 3'b000;
        step();
        vectors++;
        if (php_a !== 9'h000 || shp_a !== 1'b0) begin
            miscompares++;
            $display("FAIL all_after: pulse=%h shp=%b expected 000/0", php_a, shp_a);
        end
        frame_start();
        vectors++;
        if (hits_a !== 8'd3 || flag_a !== 9'h026) begin
            miscompares++;
            $display("FAIL all_frame: hits=%0d flag=%h expected 3/026", hits_a, flag_a);
        end
    endtask

    task automatic test_sof_overlap();
        req_a = 3'b011;
        step();
        vectors++;
        if (php_a !== 9'h002) begin
            miscompares++;
            $display("FAIL sof_mid_pulse: got %h expected 002", php_a);
        end
        sof = 1'b1;
        step();
        sof = 1'b0;
        vectors++;
        if (php_a !== 9'h000 || flag_a !== 9'h002 || hits_a !== 8'd1) begin
            miscompares++;
            $display("FAIL sof_edge: pulse=%h flag=%h hits=%0d expected 000/002/1", php_a, flag_a, hits_a);
        end
        step();
        vectors++;
        if (php_a !== 9'h002 || shp_a !== 1'b1) begin
            miscompares++;
            $display("FAIL sof_fresh: pulse=%h shp=%b expected 002/1", php_a, shp_a);
        end
        req_a = 3'b000;
        frame_start();
        vectors++;
        if (hits_a !== 8'd1 || flag_a !== 9'h002) begin
            miscompares++;
            $display("FAIL sof_next_frame: hits=%0d flag=%h expected 1/002", hits_a, flag_a);
        end
    endtask

    task automatic test_mask();
        mask_a = 9'h1FD;
        req_a  = 3'b011;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (col_a !== 1'b0 || php_a !== 9'h000) begin
                miscompares++;
                $display("FAIL mask_off: col=%b pulse=%h expected 0/000", col_a, php_a);
            end
        end
        mask_a = 9'h1FF;
        step();
        vectors++;
        if (col_a !== 1'b1 || php_a !== 9'h002) begin
            miscompares++;
            $display("FAIL mask_on: col=%b pulse=%h expected 1/002", col_a, php_a);
        end
        req_a = 3'b000;
        mask_a = 9'h1FD;
        frame_start();
        mask_a = 9'h1FF;
        vectors++;
        if (flag_a !== 9'h002 || hits_a !== 8'd1) begin
            miscompares++;
            $display("FAIL mask_frame: flag=%h hits=%0d expected 002/1", flag_a, hits_a);
        end
        req_c = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (col_c !== 1'b0 || php_c !== 16'h0000) begin
                miscompares++;
                $display("FAIL pair_en_off: col=%b pulse=%h expected 0/0000", col_c, php_c);
            end
        end
        req_c = 4'b0000;
        frame_start();
        vectors++;
        if (flag_c !== 16'h0000 || hits_c !== 2'd0) begin
            miscompares++;
            $display("FAIL pair_en_frame: flag=%h hits=%0d expected 0000/0", flag_c, hits_c);
        end
    endtask

    task automatic test_cooldown();
        logic exp_pulse;
        for (int f = 0; f < 4; f++) begin
            step();
            step();
            exp_pulse = (f == 0 || f == 3);
            req_b = 3'b011;
            sof = 1'b1;
            step();
            sof = 1'b0;
            req_b = 3'b000;
            vectors++;
            if (php_b[1] !== exp_pulse || flag_b !== 9'h002 || hits_b !== 8'(exp_pulse)) begin
                miscompares++;
                $display("FAIL cooldown_f%0d: pulse=%b flag=%h hits=%0d expected %b/002/%0d",
                         f, php_b[1], flag_b, hits_b, exp_pulse, exp_pulse);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_b = 3'b011;
        step();
        vectors++;
        if (col_b !== 1'b1 || php_b !== 9'h000) begin
            miscompares++;
            $display("FAIL cd_hold: col=%b pulse=%h expected 1/000", col_b, php_b);
        end
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if ({col_b, php_b, shp_b, flag_b, hits_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h expected 0", {col_b, php_b, shp_b, flag_b, hits_b});
        end
        step();
        resetN = 1'b1;
        step();
        vectors++;
        if (php_b !== 9'h002 || shp_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_hit: pulse=%h shp=%b expected 002/1", php_b, shp_b);
        end
        req_b = 3'b000;
        step();
    endtask

    task automatic test_saturate();
        req_c = 4'b1111;
        step();
        vectors++;
        if (php_c !== 16'h08CC || col_c !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_pulse: pulse=%h col=%b expected 08cc/1", php_c, col_c);
        end
        req_c = 4'b0000;
        frame_start();
        vectors++;
        if (hits_c !== 2'd3 || flag_c !== 16'h08CC) begin
            miscompares++;
            $display("FAIL sat_frame: hits=%0d flag=%h expected 3/08cc", hits_c, flag_c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pair();
        test_all_pairs();
        test_sof_overlap();
        test_mask();
        test_cooldown();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
